bool_func_sequencer: RTL and testbench
======================================

# bool_func_sequencer

Self-checking stimulus controller for the three-input boolean function block (F = !ABC + A!BC + AB!C). On a start request it drives every input combination {A,B,C} = 0..7 into the function block. It waits a programmable settle time per vector, samples the returned F and compares it against an expected truth table. It then reports a pass flag, a mismatch count and the first failing vector. The block sits between the lab's switch/button front end and the boolean function instance; its status outputs drive LEDs.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before F is sampled; legal range 1..15.
- EXPECTED, 8'h68: expected F per vector; bit index = {A,B,C}. Bits 3, 5 and 6 are set.
- i_clk  input  1  single clock; all state is updated on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  run request; a run starts on a rising edge of this input.
- i_F  input  1  F returned by the function block; sampled synchronously.
- o_A, o_B, o_C  output  1 each  stimulus to the function block; equal to vec[2], vec[1], vec[0].
- o_busy  output  1  high while a run is in progress.
- o_done  output  1  one-cycle pulse when a run completes.
- o_pass  output  1  high when the last completed run had zero mismatches.
- o_err_count  output  4  number of mismatches in the current or last run (0..8).
- o_fail_valid  output  1  at least one mismatch has been seen in the current or last run.
- o_first_fail  output  3  vector index of the first mismatch; valid only when o_fail_valid is high.

## Operation
- Start detect: a register holds the previous value of i_start (reset value 0). start_edge = i_start & !prev.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, on start_edge: clear vec, the settle counter, o_err_count, o_fail_valid, o_first_fail and o_pass. Next state is SETTLE.
- IDLE, without start_edge: remain in IDLE.
- SETTLE: count cycles. After SETTLE_CYCLES cycles in SETTLE, go to CHECK.
- CHECK (exactly 1 cycle): compare i_F with EXPECTED[vec].
  - On mismatch: increment o_err_count. If o_fail_valid is 0, load o_first_fail with vec and set o_fail_valid.
  - If vec == 7, go to DONE. Otherwise increment vec, reset the settle counter and go to SETTLE.
- DONE (1 cycle): assert o_done. Register o_pass as (o_err_count == 0), using the count after the final CHECK update. Clear vec, then go to IDLE.
- o_busy = (state == SETTLE or state == CHECK).
- o_A, o_B and o_C come from the vec register, so they are 0 in IDLE and after DONE.
- o_err_count is 4 bits wide and cannot overflow; the maximum value is 8.
- Results hold from DONE until the next accepted start_edge.

## Timing
- Reset values: state IDLE; vec 0; o_A, o_B, o_C 0; o_busy, o_done, o_pass, o_fail_valid 0; o_err_count 0; o_first_fail 0; prev start 0.
- Cycle 0 is the edge at which start_edge is sampled in IDLE. o_busy is high from cycle 1.
- Each vector occupies SETTLE_CYCLES + 1 cycles. Vector n is driven from cycle 1 + n·(SETTLE_CYCLES+1).
- o_busy is high for 8·(SETTLE_CYCLES+1) cycles. o_done pulses on the following cycle; with SETTLE_CYCLES = 2 that is cycle 25.
- A start_edge while busy or in DONE is ignored. The prev-start register still tracks i_start in every state.
- i_start held high across a run causes no restart; a new run needs a 0→1 transition.
- If i_start rises in the DONE cycle, that edge is ignored. If it is first seen in IDLE, the run starts.
- Reset asserted mid-run returns all outputs to their reset values immediately; no o_done is issued.
- i_F must be stable SETTLE_CYCLES cycles after the inputs change; only the CHECK-cycle sample is used.

## Test plan
- Correct function block, SETTLE_CYCLES=2, start pulse: o_A/o_B/o_C step 000→111, each held for 3 cycles. o_done at cycle 25; o_pass=1, o_err_count=0, o_fail_valid=0.
- i_F tied 0: o_err_count=3, o_first_fail=3, o_fail_valid=1, o_pass=0.
- i_F = !F (inverted model): o_err_count=8, o_first_fail=0, o_pass=0.
- Assert reset at cycle 10 of a run: all outputs return to reset values and no o_done is issued. A later start pulse then gives a normal 25-cycle run.
- Hold i_start high through a full run, and pulse it again at cycle 12: exactly one o_done and no restart. A later 0→1 transition starts a second run, and results are cleared at that start.
- SETTLE_CYCLES=1 with the correct block: o_done at cycle 17, o_pass=1.

Source files
------------

// File: rtl/bool_func_sequencer.sv
// bool_func_sequencer: drives {A,B,C} = 0..7 into a boolean function block,
// samples F after a settle time and scores it against a truth table.
module bool_func_sequencer #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h68
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_F,
    output logic       o_A,
    output logic       o_B,
    output logic       o_C,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic       o_fail_valid,
    output logic [2:0] o_first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic       fv_q, fv_d;
    logic [2:0] ff_q, ff_d;
    logic       pass_q, pass_d;
    logic       prev_q;
    logic       start_edge;

    assign start_edge = i_start & ~prev_q;

    // State and result registers; prev start tracks i_start in every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            prev_q  <= i_start;
        end
    end

    // Next-state and result update; results hold unless a step changes them.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                if (i_F != EXPECTED[vec_q]) begin
                    err_d = err_q + 4'd1;
                    if (!fv_q) begin
                        ff_d = vec_q;
                        fv_d = 1'b1;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                pass_d  = (err_q == 4'd0);
                vec_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_A          = vec_q[2];
    assign o_B          = vec_q[1];
    assign o_C          = vec_q[0];
    assign o_busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign o_done       = (state_q == DONE);
    assign o_pass       = pass_q;
    assign o_err_count  = err_q;
    assign o_fail_valid = fv_q;
    assign o_first_fail = ff_q;

endmodule

// File: tb/tb_bool_func_sequencer.sv
// tb_bool_func_sequencer: directed runs against a behavioural
// function block model (correct, tied 0, inverted).
module tb_bool_func_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       f, f1;
    logic       a, b, c, busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] ff;
    logic       a1, b1, c1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] ff1;

    int mode = 0;
    int passed = 0;
    int total = 0;
    int cyc, ndone, nbusy, at, at1, pulse_at;
    bit chkvec;

    always #5 clk = ~clk;

    function automatic logic fmodel(logic x, logic y, logic z);
        return (~x & y & z) | (x & ~y & z) | (x & y & ~z);
    endfunction

    always_comb begin
        f = fmodel(a, b, c);
        if (mode == 1) f = 1'b0;
        else if (mode == 2) f = ~fmodel(a, b, c);
        f1 = fmodel(a1, b1, c1);
    end

    bool_func_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_F(f),
        .o_A(a), .o_B(b), .o_C(c), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_err_count(err), .o_fail_valid(fv),
        .o_first_fail(ff)
    );

    bool_func_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_F(f1),
        .o_A(a1), .o_B(b1), .o_C(c1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_count(err1), .o_fail_valid(fv1),
        .o_first_fail(ff1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic go(input bit hold);
        i_start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        if (!hold) i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        ndone = 0; nbusy = 0; at = -1; at1 = -1;
        while (cyc <= limit) begin
            if (done) begin ndone++; if (at < 0) at = cyc; end
            if (done1 && at1 < 0) at1 = cyc;
            if (busy) nbusy++;
            if (chkvec && cyc <= 24)
                chk($sformatf("vec@%0d", cyc), {a, b, c}, (cyc - 1) / 3);
            if (cyc == pulse_at) i_start = 1'b0;
            if (cyc == pulse_at + 1) i_start = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; chkvec = 0; pulse_at = -1;
        repeat (2) @(negedge clk);
        chk("rst_outs", {a, b, c, busy, done, pass, fv}, 0);
        chk("rst_err", err, 0);
        chk("rst_ff", ff, 0);
        rst = 1'b0;
        @(negedge clk);

        // correct block
        mode = 0; chkvec = 1;
        go(0);
        wait_done(30);
        chkvec = 0;
        chk("ok_done_at", at, 25);
        chk("ok_ndone", ndone, 1);
        chk("ok_busy", nbusy, 24);
        chk("ok_pass", pass, 1);
        chk("ok_err", err, 0);
        chk("ok_fv", fv, 0);
        chk("ok_vec_idle", {a, b, c}, 0);

        // inverted block
        mode = 2;
        go(0);
        wait_done(30);
        chk("inv_err", err, 8);
        chk("inv_ff", ff, 0);
        chk("inv_fv", fv, 1);
        chk("inv_pass", pass, 0);

        // reset at cycle 10
        go(0);
        repeat (9) @(negedge clk);
        chk("pre_rst_err", err, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {a, b, c, busy, done, pass, fv}, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        wait_done(30);
        chk("post_rst_ndone", ndone, 0);
        chk("post_rst_busy", nbusy, 0);
        mode = 0;
        go(0);
        wait_done(30);
        chk("rerun_done_at", at, 25);
        chk("rerun_pass", pass, 1);

        // held start with re-pulse at cycle 12, tied-0 block
        mode = 1; pulse_at = 12;
        go(1);
        wait_done(45);
        pulse_at = -1;
        chk("hold_ndone", ndone, 1);
        chk("hold_busy", nbusy, 24);
        chk("hold_done_at", at, 25);
        chk("t0_err", err, 3);
        chk("t0_ff", ff, 3);
        chk("t0_fv", fv, 1);
        chk("t0_pass", pass, 0);
        i_start = 1'b0;
        @(negedge clk);

        // new run clears results; dut1 (settle 1) runs alongside
        mode = 0;
        go(0);
        chk("clr_err", err, 0);
        chk("clr_fv", fv, 0);
        chk("clr_pass", pass, 0);
        chk("clr_busy", busy, 1);
        wait_done(30);
        chk("run2_done_at", at, 25);
        chk("run2_pass", pass, 1);
        chk("s1_done_at", at1, 17);
        chk("s1_pass", pass1, 1);
        chk("s1_err", err1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
